uart_rx_sin: RTL

- UART receiver for the `uart_sin` input pad. It is the receive-side counterpart of the core's `uart_sout` transmitter path.
- Synchronizes the asynchronous pad signal and recovers 8N1 frames with 16x oversampling.
- Delivers each byte through a one-entry valid/ready holding register to the core's UART peripheral.
- Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_sin.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_sin.sv
// UART receiver for the uart_sin pad: synchronizer, 16x oversampled 8N1 frame
// recovery, one-entry valid/ready holding register, framing/overrun pulses.
module uart_rx_sin #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_sin,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  // state | meaning
  // IDLE  | line idle, waiting for sin_s low
  // START | timing to mid start bit to confirm it
  // DATA  | sampling 8 data bits LSB-first at mid-bit
  // STOP  | sampling stop bit; commit byte or flag framing error
  // BREAK | line still low after a framing error, wait for release
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sin_s;
  logic [DIV_W-1:0]       tick_cnt;
  logic [DIV_W-1:0]       tick_last;
  logic                   tick;
  logic [3:0]             os;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;

  assign sin_s = sync_q[SYNC_STAGES-1];

  // A divider of zero behaves like one: a tick every clk.
  assign tick_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick      = (state != IDLE) && (tick_cnt == tick_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state     <= IDLE;
      tick_cnt  <= '0;
      os        <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_sin};
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (tick) begin
        tick_cnt <= '0;
        os       <= os + 4'd1;
      end else if (state != IDLE) begin
        tick_cnt <= tick_cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          os       <= 4'd0;
          if (!sin_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick && os == 4'd6) begin
            if (sin_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              os      <= 4'd0;
              bit_idx <= 3'd0;
            end
          end
        end
        DATA: begin
          if (tick && os == 4'd15) begin
            shift   <= {sin_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          if (tick && os == 4'd15) begin
            if (sin_s) begin
              // A read in this same cycle frees the slot for the new byte.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (sin_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
